// File: rtl/loader_pkg.sv
// Shared types and constants for the stream-to-SRAM loader.
package loader_pkg;

  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned FRAM_ADDR_WIDTH = 10;
  localparam int unsigned KRAM_ADDR_WIDTH = 8;
  localparam int unsigned LEN_WIDTH       = 16;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_LONG  = 2'd2;
  localparam logic [1:0] ERR_RANGE = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/loader_range_chk.sv
// Combinational command legality check: zero length, misalignment, or overrun of the target SRAM.
module loader_range_chk #(
  parameter int unsigned FRAM_BYTE_ADDR_WIDTH = 12,
  parameter int unsigned KRAM_BYTE_ADDR_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH           = 12,
  parameter int unsigned LEN_WIDTH            = 16
) (
  input  logic                  target,
  input  logic [ADDR_WIDTH-1:0] byteaddr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  reject
);

  // Wide enough that addr + 4*len can never overflow.
  localparam int unsigned SumWidth = LEN_WIDTH + ADDR_WIDTH + 2;

  logic [SumWidth-1:0] end_addr;
  logic [SumWidth-1:0] limit;

  always_comb begin
    end_addr = SumWidth'(byteaddr) + (SumWidth'(len) << 2);
    limit    = target ? (SumWidth'(1) << KRAM_BYTE_ADDR_WIDTH)
                      : (SumWidth'(1) << FRAM_BYTE_ADDR_WIDTH);
    reject   = (len == '0) || (byteaddr[1:0] != 2'b00) || (end_addr > limit);
  end

endmodule

// File: rtl/stream_sram_loader.sv
// Loads an AXI-Stream of words sequentially into the feature or kernel SRAM write port.
module stream_sram_loader
  import loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH           = loader_pkg::DATA_WIDTH,
  parameter int unsigned FRAM_BYTE_ADDR_WIDTH = loader_pkg::FRAM_ADDR_WIDTH + 2,
  parameter int unsigned KRAM_BYTE_ADDR_WIDTH = loader_pkg::KRAM_ADDR_WIDTH + 2,
  parameter int unsigned LEN_WIDTH            = loader_pkg::LEN_WIDTH,
  localparam int unsigned ADDR_WIDTH = (FRAM_BYTE_ADDR_WIDTH > KRAM_BYTE_ADDR_WIDTH) ?
                                       FRAM_BYTE_ADDR_WIDTH : KRAM_BYTE_ADDR_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_target,
  input  logic [ADDR_WIDTH-1:0]           cmd_byteaddr,
  input  logic [LEN_WIDTH-1:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic                            accel_running,
  output logic [FRAM_BYTE_ADDR_WIDTH-1:0] fram_addr_byteidx,
  output logic [DATA_WIDTH-1:0]           fram_wdata,
  output logic                            fram_we,
  output logic                            fram_en,
  output logic [KRAM_BYTE_ADDR_WIDTH-1:0] kram_addr_byteidx,
  output logic [DATA_WIDTH-1:0]           kram_wdata,
  output logic                            kram_we,
  output logic                            kram_en,
  output logic                            busy,
  output logic                            load_done,
  output logic [1:0]                      err_code
);

  state_e                state_q, state_d;
  logic [1:0]            err_q, err_d;
  logic                  target_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic [LEN_WIDTH-1:0]  cnt_next;
  logic                  wr_f_q, wr_k_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept, beat, load_beat, reject, last_word;

  loader_range_chk #(
    .FRAM_BYTE_ADDR_WIDTH(FRAM_BYTE_ADDR_WIDTH),
    .KRAM_BYTE_ADDR_WIDTH(KRAM_BYTE_ADDR_WIDTH),
    .ADDR_WIDTH          (ADDR_WIDTH),
    .LEN_WIDTH           (LEN_WIDTH)
  ) u_range_chk (
    .target  (cmd_target),
    .byteaddr(cmd_byteaddr),
    .len     (cmd_len),
    .reject  (reject)
  );

  assign cmd_ready     = (state_q == StIdle) && !accel_running && !rst;
  assign s_axis_tready = (state_q == StLoad) || (state_q == StDrain);
  assign accept        = cmd_valid && cmd_ready;
  assign beat          = s_axis_tvalid && s_axis_tready;
  assign load_beat     = beat && (state_q == StLoad);
  assign cnt_next      = cnt_q + LEN_WIDTH'(1);
  assign last_word     = (cnt_next == len_q);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = reject ? StDone : StLoad;
          err_d   = reject ? ERR_RANGE : ERR_OK;
        end
      end
      StLoad: begin
        if (load_beat) begin
          if (last_word) begin
            state_d = s_axis_tlast ? StDone : StDrain;
            err_d   = s_axis_tlast ? ERR_OK : ERR_LONG;
          end else if (s_axis_tlast) begin
            state_d = StDone;
            err_d   = ERR_SHORT;
          end
        end
      end
      StDrain: begin
        if (beat && s_axis_tlast) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      err_q     <= ERR_OK;
      target_q  <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      wr_f_q    <= 1'b0;
      wr_k_q    <= 1'b0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wr_f_q  <= load_beat && !target_q;
      wr_k_q  <= load_beat && target_q;
      if (accept) begin
        target_q <= cmd_target;
        addr_q   <= cmd_byteaddr;
        len_q    <= cmd_len;
        cnt_q    <= '0;
      end
      if (load_beat) begin
        wr_addr_q <= addr_q;
        wdata_q   <= s_axis_tdata;
        addr_q    <= addr_q + ADDR_WIDTH'(4);
        cnt_q     <= cnt_next;
      end
    end
  end

  assign fram_en           = wr_f_q;
  assign fram_we           = wr_f_q;
  assign kram_en           = wr_k_q;
  assign kram_we           = wr_k_q;
  assign fram_addr_byteidx = wr_addr_q[FRAM_BYTE_ADDR_WIDTH-1:0];
  assign kram_addr_byteidx = wr_addr_q[KRAM_BYTE_ADDR_WIDTH-1:0];
  assign fram_wdata        = wdata_q;
  assign kram_wdata        = wdata_q;
  assign busy              = (state_q != StIdle);
  assign load_done         = (state_q == StDone);
  assign err_code          = err_q;

endmodule
